mem_bank_ctrl: RTL and testbench
================================

Name: mem_bank_ctrl

Overview:
- Parametrised, clocked successor to the 5-bit latch memory: DEPTH words of WIDTH bits with separate write and read ports.
- Registered read with a valid strobe and per-word "written" tracking.
- Hardware clear sequencer that sweeps the array one word per cycle.
- Sits between datapath control and any unit needing small scratch storage; replaces the latch-based store.

Parameters:
- WIDTH, 5, bits per word (min 1)
- DEPTH, 4, number of words (min 2; need not be a power of two)
- ADDR_W, derived localparam = clog2(DEPTH), address width (not overridable)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  write request, sampled at posedge
- wr_addr  input  ADDR_W  write address
- wr_data  input  WIDTH  write data
- rd_en  input  1  read request, sampled at posedge
- rd_addr  input  ADDR_W  read address
- rd_data  output  WIDTH  registered read data
- rd_valid  output  1  one-cycle strobe: rd_data valid
- rd_unwritten  output  1  qualifies rd_valid: word never written since last reset/clear, or address out of range
- clr_req  input  1  one-cycle pulse: start clear sweep
- busy  output  1  high while the clear sweep runs
- par_err  output  1  parity error on read (PARITY_EN only)

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - all storage words = 0 and all written bits = 0
  - rd_data = 0, rd_valid = 0, rd_unwritten = 0, busy = 0, par_err = 0
  - FSM = IDLE, sweep counter = 0
  - Reset mid-sweep aborts the sweep immediately.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clr_req=1 at posedge. busy=1 from the next cycle.
  - In CLEAR, each cycle: word[cnt] <= 0, written[cnt] <= 0, cnt increments.
  - CLEAR -> IDLE: after the cycle that clears word DEPTH-1. cnt returns to 0 and busy=0 from the next cycle.
  - The sweep takes exactly DEPTH cycles of busy=1.
  - clr_req during CLEAR is ignored; no restart.
- Write (IDLE only):
  - wr_en=1 at posedge with wr_addr<DEPTH: word[wr_addr] <= wr_data and written[wr_addr] <= 1.
  - wr_addr>=DEPTH: write silently dropped.
  - During CLEAR: wr_en is ignored; the write is dropped, not queued.
- Read (IDLE only):
  - rd_en=1 at posedge: on the next posedge rd_data = word[rd_addr] and rd_valid=1 for exactly one cycle. Latency is 1 cycle.
  - rd_unwritten = !written[rd_addr], with the same timing as rd_valid.
  - rd_addr>=DEPTH: rd_data=0, rd_unwritten=1.
  - rd_data holds its last value when rd_valid=0.
  - During CLEAR: rd_en is ignored; rd_valid stays 0.
- Same-cycle read and write to the same address: read-before-write. rd_data returns the old word and the old written flag. A read in the following cycle sees the new data.
- clr_req in the same cycle as wr_en/rd_en while IDLE: the write and read are performed that cycle, then CLEAR starts. Read data is delivered normally during the first busy cycle.
- Back-to-back reads are allowed every cycle, giving one rd_valid per request.

Optional Feature:
- Macro: MEM_BANK_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed as XOR of wr_data on write.
  - On read, par_err is asserted with rd_valid when the stored parity does not match the recomputed parity of the stored data.
  - Clear and reset store parity 0.
  - A test-only input port inj_par (1 bit) inverts the stored parity bit on a write when high.
- Not defined:
  - No parity storage and no inj_par port.
  - par_err is tied to 0.

Test Plan:
1. WIDTH=5, DEPTH=4, after reset: read addr 2 -> one cycle later rd_valid=1, rd_data=0, rd_unwritten=1.
2. Write 5'b10110 to addr 1, then read addr 1 next cycle -> rd_data=5'b10110, rd_unwritten=0, rd_valid high for exactly one cycle.
3. Same cycle: write 5'b00011 and read addr 3, where addr 3 holds 5'b11100 -> rd_data=5'b11100. A read the next cycle -> 5'b00011.
4. Fill all 4 words, pulse clr_req -> busy=1 for exactly 4 cycles; a write of 5'b11111 to addr 0 during busy is dropped. After busy falls, reading addr 0..3 gives 0 with rd_unwritten=1.
5. DEPTH=3 (ADDR_W=2): write to addr 3 is dropped; read addr 3 -> rd_data=0, rd_unwritten=1. Assert rst in the 2nd cycle of a sweep -> busy=0 immediately and all outputs reset.
6. MEM_BANK_PARITY_EN defined: write 5'b10101 with inj_par=1, then read -> par_err=1 with rd_valid. Rewrite with inj_par=0, then read -> par_err=0.

Source files
------------

// File: rtl/mem_bank_if.sv
// Bus bundle for mem_bank_ctrl: write port, read port, clear request and status.
// The parity test input inj_par exists only when MEM_BANK_PARITY_EN is defined.
interface mem_bank_if #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_unwritten;
    logic              clr_req;
    logic              busy;
    logic              par_err;
`ifdef MEM_BANK_PARITY_EN
    logic              inj_par;
`endif

    // Requester side
    modport master (
`ifdef MEM_BANK_PARITY_EN
        output inj_par,
`endif
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, rd_unwritten, busy, par_err
    );

    // Memory side
    modport slave (
`ifdef MEM_BANK_PARITY_EN
        input  inj_par,
`endif
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, rd_unwritten, busy, par_err
    );
endinterface

// File: rtl/mem_bank_ctrl.sv
// Small clocked scratch memory: DEPTH x WIDTH words, 1-cycle registered read with
// valid strobe, per-word written tracking and a one-word-per-cycle clear sweep.
// Optional even-parity storage enabled by defining MEM_BANK_PARITY_EN.
module mem_bank_ctrl #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    mem_bank_if.slave bus
);
    localparam int unsigned        ADDR_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0]    DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]   written_q, written_d;
    logic [WIDTH-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               rd_unwritten_q, rd_unwritten_d;
    logic               busy_q, busy_d;
`ifdef MEM_BANK_PARITY_EN
    logic [DEPTH-1:0]   par_q, par_d;
    logic               par_err_q, par_err_d;
`endif

    logic               wr_in_range_c;
    logic               rd_in_range_c;

    // Address range qualification (DEPTH need not be a power of two)
    assign wr_in_range_c = ({1'b0, bus.wr_addr} < DEPTH_C);
    assign rd_in_range_c = ({1'b0, bus.rd_addr} < DEPTH_C);

    // Next-state: sweep sequencing, writes, read capture (read sees pre-write contents)
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mem_d          = mem_q;
        written_d      = written_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = 1'b0;
        rd_unwritten_d = 1'b0;
        busy_d         = busy_q;
`ifdef MEM_BANK_PARITY_EN
        par_d          = par_q;
        par_err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.rd_en) begin
                    rd_valid_d = 1'b1;
                    if (rd_in_range_c) begin
                        rd_data_d      = mem_q[bus.rd_addr];
                        rd_unwritten_d = ~written_q[bus.rd_addr];
`ifdef MEM_BANK_PARITY_EN
                        par_err_d      = par_q[bus.rd_addr] ^ (^mem_q[bus.rd_addr]);
`endif
                    end else begin
                        rd_data_d      = '0;
                        rd_unwritten_d = 1'b1;
                    end
                end
                if (bus.wr_en && wr_in_range_c) begin
                    mem_d[bus.wr_addr]     = bus.wr_data;
                    written_d[bus.wr_addr] = 1'b1;
`ifdef MEM_BANK_PARITY_EN
                    par_d[bus.wr_addr]     = (^bus.wr_data) ^ bus.inj_par;
`endif
                end
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                mem_d[cnt_q]     = '0;
                written_d[cnt_q] = 1'b0;
`ifdef MEM_BANK_PARITY_EN
                par_d[cnt_q]     = 1'b0;
`endif
                if (cnt_q == LAST_C) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and storage registers; reset aborts any sweep in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            written_q      <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_unwritten_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef MEM_BANK_PARITY_EN
            par_q          <= '0;
            par_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mem_q          <= mem_d;
            written_q      <= written_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            rd_unwritten_q <= rd_unwritten_d;
            busy_q         <= busy_d;
`ifdef MEM_BANK_PARITY_EN
            par_q          <= par_d;
            par_err_q      <= par_err_d;
`endif
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_unwritten = rd_unwritten_q;
    assign bus.busy         = busy_q;
`ifdef MEM_BANK_PARITY_EN
    assign bus.par_err      = par_err_q;
`else
    assign bus.par_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Testbench for mem_bank_ctrl: table of directed vectors on a DEPTH=4 instance,
// hand sequences for non-power-of-two DEPTH=3, mid-sweep reset and parity.
module tb_mem_bank_ctrl;

    logic clk;
    logic rst;

    mem_bank_if #(.WIDTH(5), .DEPTH(4)) bus_a ();
    mem_bank_if #(.WIDTH(5), .DEPTH(3)) bus_b ();

    mem_bank_ctrl #(.WIDTH(5), .DEPTH(4)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_bank_ctrl #(.WIDTH(5), .DEPTH(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [4:0] wd;
        logic       re;
        logic [1:0] ra;
        logic       clr;
        logic       exp_valid;
        logic       exp_busy;
        logic       chk_data;
        logic [4:0] exp_data;
        logic       exp_unw;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic we, input logic [1:0] wa, input logic [4:0] wd,
                         input logic re, input logic [1:0] ra, input logic clr);
        bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd;
        bus_a.rd_en = re; bus_a.rd_addr = ra; bus_a.clr_req = clr;
    endtask

    task automatic set_b(input logic we, input logic [1:0] wa, input logic [4:0] wd,
                         input logic re, input logic [1:0] ra, input logic clr);
        bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd;
        bus_b.rd_en = re; bus_b.rd_addr = ra; bus_b.clr_req = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Each row's expectations are the outputs after that row's clock edge.
        //            we wa  wd        re ra  clr  v  b  cd data      unw
        vecs[0]  = '{0, 2'd0, 5'b00000, 1, 2'd2, 0, 1, 0, 1, 5'b00000, 1};
        vecs[1]  = '{0, 2'd0, 5'b00000, 0, 2'd0, 0, 0, 0, 1, 5'b00000, 0};
        vecs[2]  = '{1, 2'd1, 5'b10110, 0, 2'd0, 0, 0, 0, 0, 5'b00000, 0};
        vecs[3]  = '{0, 2'd0, 5'b00000, 1, 2'd1, 0, 1, 0, 1, 5'b10110, 0};
        vecs[4]  = '{0, 2'd0, 5'b00000, 0, 2'd0, 0, 0, 0, 1, 5'b10110, 0};
        vecs[5]  = '{1, 2'd3, 5'b11100, 0, 2'd0, 0, 0, 0, 0, 5'b00000, 0};
        vecs[6]  = '{1, 2'd3, 5'b00011, 1, 2'd3, 0, 1, 0, 1, 5'b11100, 0};
        vecs[7]  = '{0, 2'd0, 5'b00000, 1, 2'd3, 0, 1, 0, 1, 5'b00011, 0};
        vecs[8]  = '{1, 2'd0, 5'b00001, 1, 2'd2, 0, 1, 0, 1, 5'b00000, 1};
        vecs[9]  = '{1, 2'd2, 5'b01010, 1, 2'd0, 0, 1, 0, 1, 5'b00001, 0};
        vecs[10] = '{0, 2'd0, 5'b00000, 1, 2'd2, 0, 1, 0, 1, 5'b01010, 0};
        vecs[11] = '{0, 2'd0, 5'b00000, 1, 2'd1, 0, 1, 0, 1, 5'b10110, 0};
        vecs[12] = '{1, 2'd1, 5'b11001, 1, 2'd1, 1, 1, 1, 1, 5'b10110, 0};
        vecs[13] = '{1, 2'd0, 5'b11111, 1, 2'd0, 0, 0, 1, 1, 5'b10110, 0};
        vecs[14] = '{0, 2'd0, 5'b00000, 0, 2'd0, 1, 0, 1, 0, 5'b00000, 0};
        vecs[15] = '{0, 2'd0, 5'b00000, 0, 2'd0, 0, 0, 1, 0, 5'b00000, 0};
        vecs[16] = '{0, 2'd0, 5'b00000, 0, 2'd0, 0, 0, 0, 0, 5'b00000, 0};
        vecs[17] = '{0, 2'd0, 5'b00000, 1, 2'd0, 0, 1, 0, 1, 5'b00000, 1};
        vecs[18] = '{0, 2'd0, 5'b00000, 1, 2'd1, 0, 1, 0, 1, 5'b00000, 1};
        vecs[19] = '{0, 2'd0, 5'b00000, 1, 2'd2, 0, 1, 0, 1, 5'b00000, 1};
        vecs[20] = '{0, 2'd0, 5'b00000, 1, 2'd3, 0, 1, 0, 1, 5'b00000, 1};
        vecs[21] = '{1, 2'd0, 5'b11111, 0, 2'd0, 0, 0, 0, 0, 5'b00000, 0};
        vecs[22] = '{0, 2'd0, 5'b00000, 1, 2'd0, 0, 1, 0, 1, 5'b11111, 0};

        rst = 1'b1;
        set_a(0, 2'd0, 5'd0, 0, 2'd0, 0);
        set_b(0, 2'd0, 5'd0, 0, 2'd0, 0);
`ifdef MEM_BANK_PARITY_EN
        bus_a.inj_par = 1'b0;
        bus_b.inj_par = 1'b0;
`endif
        repeat (3) step();

        // Reset state
        check("reset a rd_data", 32'(bus_a.rd_data), 32'd0);
        check("reset a rd_valid", 32'(bus_a.rd_valid), 32'd0);
        check("reset a rd_unwritten", 32'(bus_a.rd_unwritten), 32'd0);
        check("reset a busy", 32'(bus_a.busy), 32'd0);
        check("reset a par_err", 32'(bus_a.par_err), 32'd0);
        check("reset b busy", 32'(bus_b.busy), 32'd0);
        rst = 1'b0;
        step();

        // Table-driven sequence on DEPTH=4
        for (int i = 0; i < NV; i++) begin
            set_a(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].clr);
            step();
            check($sformatf("row%0d rd_valid", i), 32'(bus_a.rd_valid), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d busy", i), 32'(bus_a.busy), 32'(vecs[i].exp_busy));
            check($sformatf("row%0d par_err", i), 32'(bus_a.par_err), 32'd0);
            if (vecs[i].chk_data)
                check($sformatf("row%0d rd_data", i), 32'(bus_a.rd_data), 32'(vecs[i].exp_data));
            if (vecs[i].exp_valid)
                check($sformatf("row%0d rd_unwritten", i), 32'(bus_a.rd_unwritten), 32'(vecs[i].exp_unw));
        end
        set_a(0, 2'd0, 5'd0, 0, 2'd0, 0);
        step();

`ifdef MEM_BANK_PARITY_EN
        // Injected parity error is reported, a clean rewrite clears it
        bus_a.inj_par = 1'b1;
        set_a(1, 2'd2, 5'b10101, 0, 2'd0, 0);
        step();
        bus_a.inj_par = 1'b0;
        set_a(0, 2'd0, 5'd0, 1, 2'd2, 0);
        step();
        check("parity inj rd_valid", 32'(bus_a.rd_valid), 32'd1);
        check("parity inj par_err", 32'(bus_a.par_err), 32'd1);
        check("parity inj rd_data", 32'(bus_a.rd_data), 32'(5'b10101));
        set_a(1, 2'd2, 5'b10101, 0, 2'd0, 0);
        step();
        set_a(0, 2'd0, 5'd0, 1, 2'd2, 0);
        step();
        check("parity clean rd_valid", 32'(bus_a.rd_valid), 32'd1);
        check("parity clean par_err", 32'(bus_a.par_err), 32'd0);
        set_a(0, 2'd0, 5'd0, 0, 2'd0, 0);
        step();
`endif

        // DEPTH=3: out-of-range write dropped, out-of-range read returns 0/unwritten
        set_b(1, 2'd3, 5'b11111, 0, 2'd0, 0);
        step();
        set_b(0, 2'd0, 5'd0, 1, 2'd3, 0);
        step();
        check("b oor rd_valid", 32'(bus_b.rd_valid), 32'd1);
        check("b oor rd_data", 32'(bus_b.rd_data), 32'd0);
        check("b oor rd_unwritten", 32'(bus_b.rd_unwritten), 32'd1);

        // Sweep on DEPTH=3 lasts exactly 3 busy cycles
        set_b(0, 2'd0, 5'd0, 0, 2'd0, 1);
        step();
        set_b(0, 2'd0, 5'd0, 0, 2'd0, 0);
        n = 0;
        while (bus_b.busy && n < 20) begin
            n++;
            step();
        end
        check("b sweep length", 32'(n), 32'd3);

        // Read delivered in first busy cycle, then reset in second sweep cycle
        set_b(1, 2'd2, 5'b10101, 0, 2'd0, 0);
        step();
        set_b(0, 2'd0, 5'd0, 1, 2'd2, 1);
        step();
        check("b clr+rd rd_valid", 32'(bus_b.rd_valid), 32'd1);
        check("b clr+rd rd_data", 32'(bus_b.rd_data), 32'(5'b10101));
        check("b clr+rd busy", 32'(bus_b.busy), 32'd1);
        set_b(0, 2'd0, 5'd0, 0, 2'd0, 0);
        step();
        check("b sweep2 busy", 32'(bus_b.busy), 32'd1);
        check("b sweep2 rd_valid", 32'(bus_b.rd_valid), 32'd0);
        check("b sweep2 rd_data hold", 32'(bus_b.rd_data), 32'(5'b10101));
        rst = 1'b1;
        #1;
        check("b async rst busy", 32'(bus_b.busy), 32'd0);
        check("b async rst rd_data", 32'(bus_b.rd_data), 32'd0);
        check("b async rst rd_valid", 32'(bus_b.rd_valid), 32'd0);
        check("b async rst rd_unwritten", 32'(bus_b.rd_unwritten), 32'd0);
        check("b async rst par_err", 32'(bus_b.par_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("b post rst busy", 32'(bus_b.busy), 32'd0);
        set_b(0, 2'd0, 5'd0, 1, 2'd2, 0);
        step();
        check("b post rst rd_valid", 32'(bus_b.rd_valid), 32'd1);
        check("b post rst rd_data", 32'(bus_b.rd_data), 32'd0);
        check("b post rst rd_unwritten", 32'(bus_b.rd_unwritten), 32'd1);
        set_b(0, 2'd0, 5'd0, 0, 2'd0, 0);
        step();
        check("b idle rd_valid", 32'(bus_b.rd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
